// File: rtl/cpu_pkg.sv
// Shared definitions for the 32-bit core: opcodes, fetch state encoding, reset PC.
package cpu_pkg;

    localparam logic [5:0] OP_BEQ = 6'b100011;
    localparam logic [5:0] OP_BNE = 6'b100111;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t StFetch   = 2'd0;
    localparam fetch_state_t StIssue   = 2'd1;
    localparam fetch_state_t StResolve = 2'd2;
    localparam fetch_state_t StHalt    = 2'd3;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jr > jump > taken branch > fall-through.
module next_pc_calc (
    input  logic [31:0] pc_plus4,
    input  logic [31:0] inst,
    input  logic        branch,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        alu_zero,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic        taken;
    logic [31:0] branch_off;
    logic        unused_inst;

    // beq and bne differ only in inst[28]
    assign taken       = inst[28] ? !alu_zero : alu_zero;
    assign branch_off  = {{14{inst[15]}}, inst[15:0], 2'b00};
    assign unused_inst = ^{inst[31:29], inst[27:26]};

    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
        end else if (branch && taken) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Single-issue fetch sequencer: FETCH -> ISSUE -> RESOLVE, one instruction in flight.
// IFETCH_ALIGN_CHECK_EN: misaligned next PC halts with fault instead of being truncated.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [5:0]  opcode,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        res_valid,
    input  logic        branch,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        alu_zero,
    input  logic [31:0] jr_target,
    output logic        fault
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_plus4_q, inst_q;
    logic [31:0]  target, next_pc;
    logic         imem_req_q, inst_valid_q;
    logic         fetch_accept, pc_load;

    next_pc_calc u_next_pc_calc (
        .pc_plus4  (pc_plus4_q),
        .inst      (inst_q),
        .branch    (branch),
        .jump      (jump),
        .jump_reg  (jump_reg),
        .alu_zero  (alu_zero),
        .jr_target (jr_target),
        .next_pc   (target)
    );

`ifdef IFETCH_ALIGN_CHECK_EN
    logic misaligned;
    logic fault_q;

    assign next_pc    = target;
    assign misaligned = |target[1:0];
`else
    assign next_pc = {target[31:2], 2'b00};
`endif

    assign fetch_accept = imem_req_q && imem_ack;

    always_comb begin
        state_d = state_q;
        pc_load = 1'b0;
        case (state_q)
            StFetch: begin
                if (fetch_accept) state_d = StIssue;
            end
            StIssue: begin
                if (inst_valid_q && inst_ready) state_d = StResolve;
            end
            StResolve: begin
                if (res_valid) begin
`ifdef IFETCH_ALIGN_CHECK_EN
                    if (misaligned) begin
                        state_d = StHalt;
                    end else begin
                        pc_load = 1'b1;
                        state_d = StFetch;
                    end
`else
                    pc_load = 1'b1;
                    state_d = StFetch;
`endif
                end
            end
`ifdef IFETCH_ALIGN_CHECK_EN
            StHalt: state_d = StHalt;
`endif
            default: state_d = StFetch;
        endcase
    end

    // Request/valid are registered from the next state so they align with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            pc_plus4_q   <= RESET_PC + 32'd4;
            inst_q       <= '0;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            imem_req_q   <= (state_d == StFetch);
            inst_valid_q <= (state_d == StIssue);
            if (fetch_accept) inst_q <= imem_rdata;
            if (pc_load) begin
                pc_q       <= next_pc;
                pc_plus4_q <= next_pc + 32'd4;
            end
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= (state_d == StHalt);
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign opcode     = inst_q[31:26];
    assign pc_out     = pc_q;
    assign pc_plus4   = pc_plus4_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequencing, branches, jumps, backpressure, resets,
// misaligned jr (behaviour follows IFETCH_ALIGN_CHECK_EN).
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] JR_WORD  = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        res_valid;
    logic        branch;
    logic        jump;
    logic        jump_reg;
    logic        alu_zero;
    logic [31:0] jr_target;
    logic        fault;

    int checks_total  = 0;
    int checks_passed = 0;

    instruction_fetch #(
        .RESET_PC (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .opcode     (opcode),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .res_valid  (res_valid),
        .branch     (branch),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .alu_zero   (alu_zero),
        .jr_target  (jr_target),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clear_res();
        res_valid = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        jump_reg  = 1'b0;
        alu_zero  = 1'b0;
        jr_target = 32'h0;
    endtask

    // Noise on resolution inputs that must be ignored outside RESOLVE
    task automatic res_noise();
        res_valid = 1'b1;
        jump_reg  = 1'b1;
        jr_target = 32'hDEAD_0000;
    endtask

    // Releases reset at a falling edge; returns at the falling edge where FETCH requests RESET_PC
    task automatic reset_release(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq({tag, " req"}, {31'b0, imem_req}, 32'd1);
        check_eq({tag, " addr"}, imem_addr, RESET_PC);
        check_eq({tag, " inst"}, inst, 32'h0);
        check_eq({tag, " valid"}, {31'b0, inst_valid}, 32'd0);
        check_eq({tag, " fault"}, {31'b0, fault}, 32'd0);
        check_eq({tag, " pc_plus4"}, pc_plus4, RESET_PC + 32'd4);
    endtask

    // Entered at a falling edge with the DUT in FETCH; returns at the falling edge after resolution
    task automatic run_inst(input string tag, input logic [31:0] addr, input logic [31:0] word,
                            input int ack_dly, input int rdy_dly, input logic br,
                            input logic jp, input logic jr, input logic zero,
                            input logic [31:0] jrt);
        imem_rdata = word;
        imem_ack   = (ack_dly == 0);
        for (int i = 0; i < ack_dly; i++) begin
            res_noise();
            check_eq({tag, " wait req"}, {31'b0, imem_req}, 32'd1);
            check_eq({tag, " wait addr"}, imem_addr, addr);
            @(negedge clk);
        end
        clear_res();
        imem_ack = 1'b1;
        check_eq({tag, " req"}, {31'b0, imem_req}, 32'd1);
        check_eq({tag, " addr"}, imem_addr, addr);
        @(negedge clk);
        check_eq({tag, " valid"}, {31'b0, inst_valid}, 32'd1);
        check_eq({tag, " inst"}, inst, word);
        check_eq({tag, " opcode"}, {26'b0, opcode}, {26'b0, word[31:26]});
        check_eq({tag, " pc_out"}, pc_out, addr);
        check_eq({tag, " pc_plus4"}, pc_plus4, addr + 32'd4);
        inst_ready = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            res_noise();
            @(negedge clk);
            check_eq({tag, " stall valid"}, {31'b0, inst_valid}, 32'd1);
            check_eq({tag, " stall inst"}, inst, word);
            check_eq({tag, " stall req"}, {31'b0, imem_req}, 32'd0);
        end
        clear_res();
        inst_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, " resolve valid"}, {31'b0, inst_valid}, 32'd0);
        check_eq({tag, " resolve req"}, {31'b0, imem_req}, 32'd0);
        branch    = br;
        jump      = jp;
        jump_reg  = jr;
        alu_zero  = zero;
        jr_target = jrt;
        res_valid = 1'b1;
        @(negedge clk);
        clear_res();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        inst_ready = 1'b1;
        clear_res();
        repeat (2) @(negedge clk);
        check_eq("rst req", {31'b0, imem_req}, 32'd0);
        check_eq("rst valid", {31'b0, inst_valid}, 32'd0);
        check_eq("rst inst", inst, 32'h0);
        check_eq("rst fault", {31'b0, fault}, 32'd0);
        reset_release("rel");

        // Sequential fetch at 3-cycle spacing
        run_inst("seq0", 32'h0000_0100, 32'h2001_0005, 0, 0, 0, 0, 0, 0, 32'h0);
        run_inst("seq1", 32'h0000_0104, NOP, 0, 0, 0, 0, 0, 0, 32'h0);
        run_inst("seq2", 32'h0000_0108, JR_WORD, 0, 0, 0, 0, 1, 0, 32'h0000_0200);

        // beq/bne with imm = -2
        run_inst("beq_t", 32'h0000_0200, 32'h8C00_FFFE, 0, 0, 1, 0, 0, 1, 32'h0);
        run_inst("jr_a", 32'h0000_01FC, JR_WORD, 0, 0, 0, 0, 1, 0, 32'h0000_0200);
        run_inst("beq_nt", 32'h0000_0200, 32'h8C00_FFFE, 0, 0, 1, 0, 0, 0, 32'h0);
        run_inst("jr_b", 32'h0000_0204, JR_WORD, 0, 0, 0, 0, 1, 0, 32'h0000_0200);
        run_inst("bne_nt", 32'h0000_0200, 32'h9C00_FFFE, 0, 0, 1, 0, 0, 1, 32'h0);
        run_inst("bne_t", 32'h0000_0204, 32'h9C00_FFFE, 0, 0, 1, 0, 0, 0, 32'h0);

        // Jumps and priority
        run_inst("jr_jmp", 32'h0000_0200, JR_WORD, 0, 0, 0, 1, 1, 0, 32'h1000_0000);
        run_inst("j", 32'h1000_0000, 32'h0800_0040, 0, 0, 0, 1, 0, 0, 32'h0);
        run_inst("j_br", 32'h1000_0100, 32'h0800_0080, 0, 0, 1, 1, 0, 1, 32'h0);

        // Backpressure on both sides, then fall-through wrap
        run_inst("bp", 32'h1000_0200, JR_WORD, 4, 3, 0, 0, 1, 0, 32'hFFFF_FFFC);
        run_inst("wrap", 32'hFFFF_FFFC, NOP, 0, 0, 0, 0, 0, 0, 32'h0);
        run_inst("misal", 32'h0000_0000, JR_WORD, 0, 0, 0, 0, 1, 0, 32'h0000_0302);

`ifdef IFETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            check_eq("halt fault", {31'b0, fault}, 32'd1);
            check_eq("halt req", {31'b0, imem_req}, 32'd0);
            check_eq("halt valid", {31'b0, inst_valid}, 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_eq("halt rst fault", {31'b0, fault}, 32'd0);
        reset_release("halt rel");
`else
        check_eq("misal fault", {31'b0, fault}, 32'd0);
        run_inst("aligned", 32'h0000_0300, NOP, 0, 0, 0, 0, 0, 0, 32'h0);
`endif

        // Reset during FETCH-wait
        imem_ack = 1'b0;
        @(negedge clk);
        check_eq("mrf req pre", {31'b0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mrf req", {31'b0, imem_req}, 32'd0);
        check_eq("mrf valid", {31'b0, inst_valid}, 32'd0);
        imem_ack = 1'b1;
        reset_release("mrf rel");

        // Reset during ISSUE
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        check_eq("mri valid pre", {31'b0, inst_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mri valid", {31'b0, inst_valid}, 32'd0);
        check_eq("mri inst", inst, 32'h0);
        reset_release("mri rel");

        // Reset during RESOLVE with a pending jr
        inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        res_valid = 1'b1;
        jump_reg  = 1'b1;
        jr_target = 32'h0000_0500;
        rst_n     = 1'b0;
        #1;
        check_eq("mrr req", {31'b0, imem_req}, 32'd0);
        check_eq("mrr valid", {31'b0, inst_valid}, 32'd0);
        clear_res();
        reset_release("mrr rel");
        run_inst("post", RESET_PC, NOP, 0, 0, 0, 0, 0, 0, 32'h0);
        check_eq("post addr", imem_addr, RESET_PC + 32'd4);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
